// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch stage of the 8-bit microprocessor. Reads the program
// counter, issues a read to program memory, stores the returned byte in a
// 2-entry instruction queue feeding decode, and requests one PC increment
// per accepted fetch. A flush (branch/jump) discards the queue and any
// outstanding fetch; halt stops new requests from being started.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   PC        in   current program counter
//   PC_inc    out  one-cycle increment request to the PC
//   mem_rd    out  program memory read request
//   mem_addr  out  read address (always equal to PC)
//   mem_rdy   in   mem_data valid this cycle (only meaningful while mem_rd=1)
//   mem_data  in   read data
//   ir        out  instruction at queue head (0 when empty)
//   ir_valid  out  queue non-empty
//   ir_ready  in   decode accepts ir this cycle
//   flush     in   discard queue and outstanding fetch; PC is being loaded
//   halt      in   do not start new requests
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    output logic              PC_inc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              flush,
    input  logic              halt
);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_REQ   = 2'd1,
        ST_INC   = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        count_r;
    logic [1:0]        count_next_s;
    logic              head_r;
    logic              tail_r;
    logic [DATA_W-1:0] entry_r [2];
    logic              push_s;
    logic              pop_s;

    // Queue push/pop qualification; flush cancels both the response and the pop.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = (state_r == ST_REQ) && mem_rdy;
            pop_s  = (count_r != 2'd0) && ir_ready;
        end
    end

    // Occupancy after the coming edge; the FSM decides INC/FULL exits on it.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - 2'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_FLUSH: begin
                    if (halt) state_next_s = ST_FLUSH;
                    else      state_next_s = ST_REQ;
                end
                ST_REQ: begin
                    // halt never aborts a request already on the bus
                    if (mem_rdy) state_next_s = ST_INC;
                    else         state_next_s = ST_REQ;
                end
                ST_INC: begin
                    if ((count_next_s == 2'd2) || halt) state_next_s = ST_FULL;
                    else                                state_next_s = ST_REQ;
                end
                ST_FULL: begin
                    if ((count_next_s != 2'd2) && !halt) state_next_s = ST_REQ;
                    else                                 state_next_s = ST_FULL;
                end
                default: state_next_s = ST_FLUSH;
            endcase
        end
    end

    // Output decode from the state and queue registers.
    always_comb begin
        mem_rd   = (state_r == ST_REQ);
        PC_inc   = (state_r == ST_INC) && !flush;
        mem_addr = PC;
        ir_valid = (count_r != 2'd0);
        if (count_r != 2'd0) begin
            ir = entry_r[head_r];
        end else begin
            ir = {DATA_W{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FLUSH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction queue storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 2'd0;
            head_r     <= 1'b0;
            tail_r     <= 1'b0;
            entry_r[0] <= {DATA_W{1'b0}};
            entry_r[1] <= {DATA_W{1'b0}};
        end else begin
            count_r <= count_next_s;
            if (flush) begin
                head_r <= 1'b0;
                tail_r <= 1'b0;
            end else begin
                if (push_s) begin
                    entry_r[tail_r] <= mem_data;
                    tail_r          <= tail_r + 1'b1;
                end
                if (pop_s) begin
                    head_r <= head_r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios followed by
// randomized traffic. Memory returns mem_data = address + 8'h10. A monitor
// keeps a queue of the instructions decode should see (address stream
// restarting at each flush/reset target) and compares on every cycle.
module tb_fetch_unit;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] PC       = 8'h00;
    logic       mem_rdy  = 1'b0;
    logic       ir_ready = 1'b1;
    logic       flush    = 1'b0;
    logic       halt     = 1'b0;
    logic       PC_inc;
    logic       mem_rd;
    logic       ir_valid;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] ir;

    int         n_cmp       = 0;
    int         n_bad       = 0;
    int         n_pop       = 0;
    int         fixed_waits = 0;
    int         waits       = 0;
    int         req_age     = 0;
    bit         rand_mode   = 1'b0;
    logic [7:0] flush_target = 8'h00;

    // values seen just before each active edge, used by the PC/memory models
    logic s_inc = 1'b0, s_flush = 1'b0, s_rst = 1'b0, s_rd = 1'b0, s_rdy = 1'b0;

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] next_addr = 8'h00;
    logic       pend_inc  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    assign mem_data = mem_fn(mem_addr);

    fetch_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .PC       (PC),
        .PC_inc   (PC_inc),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data),
        .ir       (ir),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .flush    (flush),
        .halt     (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pre-edge sampler for the environment models.
    initial forever begin
        @(negedge clk);
        s_inc   = PC_inc;
        s_flush = flush;
        s_rst   = rst;
        s_rd    = mem_rd;
        s_rdy   = mem_rdy;
    end

    // Monitor / scoreboard: checks outputs mid-cycle, then applies this cycle's events.
    initial forever begin
        @(negedge clk);
        chk("mem_addr", mem_addr, PC);
        if (rst) begin
            exp_q.delete();
            pend_inc  = 1'b0;
            next_addr = 8'h00;
        end else begin
            chk("pc_inc", PC_inc, pend_inc && !flush);
            chk("ir_valid", ir_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("ir", ir, exp_q[0]);
            else                   chk("ir_empty", ir, 8'h00);
            if (flush) begin
                exp_q.delete();
                pend_inc  = 1'b0;
                next_addr = flush_target;
            end else begin
                if (ir_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
                pend_inc = mem_rdy;
                if (mem_rdy) begin
                    exp_q.push_back(mem_fn(next_addr));
                    next_addr = next_addr + 8'h01;
                    chk("queue_depth", exp_q.size() <= 2, 1'b1);
                end
            end
        end
    end

    // Advance one clock: update PC register model and memory responder.
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_rst)        PC = 8'h00;
        else if (s_flush) PC = flush_target;
        else if (s_inc)   PC = PC + 8'h01;
        if (s_rd && !s_rdy && !s_flush && !s_rst) req_age++;
        else                                      req_age = 0;
        if (req_age == 0) waits = rand_mode ? int'($urandom_range(0, 3)) : fixed_waits;
        mem_rdy = mem_rd && (req_age >= waits);
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic fl, input logic h,
                       input logic [7:0] tgt);
        tick();
        rst      = r;
        ir_ready = rdy;
        flush    = fl;
        halt     = h;
        if (fl) flush_target = tgt;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic h;
        h = 1'b0;

        // reset and startup with zero-wait memory
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_pc_inc", PC_inc, 1'b0);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_ir", ir, 8'h00);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("start_mem_rd", mem_rd, (k % 2) == 1);
            chk("start_pc_inc", PC_inc, (k >= 2) && (k % 2 == 0));
            chk("start_ir_valid", ir_valid, (k >= 2) && (k % 2 == 0));
            chk("start_ir", ir, ((k >= 2) && (k % 2 == 0)) ? (8'h10 + 8'(k / 2 - 1)) : 8'h00);
        end

        // wait states: flush (lands in INC) then 3-cycle memory latency
        fixed_waits = 3;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h40);
        chk("flush_in_inc_pc_inc", PC_inc, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("flush1_mem_rd", mem_rd, 1'b0);
        chk("flush1_ir_valid", ir_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("wait_mem_rd", mem_rd, 1'b1);
            chk("wait_mem_addr", mem_addr, 8'h40);
            chk("wait_pc_inc", PC_inc, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("wait_inc", PC_inc, 1'b1);
        chk("wait_ir", ir, 8'h50);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("wait_next_addr", mem_addr, 8'h41);
        chk("wait_next_rd", mem_rd, 1'b1);

        // backpressure: two fetches fill the queue
        fixed_waits = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("full_mem_rd", mem_rd, 1'b0);
        chk("full_ir", ir, 8'h90);
        chk("full_ir_valid", ir_valid, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("full_pop_mem_rd", mem_rd, 1'b0);
        // flush during REQ with a response and one queued entry
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hC0);
        chk("resume_mem_rd", mem_rd, 1'b1);
        chk("resume_addr", mem_addr, 8'h82);
        chk("resume_ir", ir, 8'h91);
        chk("flush_req_pc_inc", PC_inc, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("flush2_ir_valid", ir_valid, 1'b0);
        chk("flush2_pc_inc", PC_inc, 1'b0);
        chk("flush2_mem_rd", mem_rd, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("flush2_new_addr", mem_addr, 8'hC0);
        chk("flush2_new_rd", mem_rd, 1'b1);
        // flush in the INC cycle
        fixed_waits = 2;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hD0);
        chk("flush3_inc_suppressed", PC_inc, 1'b0);
        chk("flush3_ir", ir, 8'hD0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("flush3_ir_valid", ir_valid, 1'b0);

        // halt during a delayed request
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("halt_req_addr", mem_addr, 8'hD0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("halt_req_held", mem_rd, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("halt_req_held2", mem_rd, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("halt_inc", PC_inc, 1'b1);
        chk("halt_ir", ir, 8'hE0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("halt_idle_rd", mem_rd, 1'b0);
        fixed_waits = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("halt_idle_rd2", mem_rd, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("unhalt_rd", mem_rd, 1'b1);
        chk("unhalt_addr", mem_addr, 8'hD1);

        // simultaneous push and pop
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("pp_first_ir", ir, 8'hE1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pp_req_ir", ir, 8'hE1);
        chk("pp_req_rd", mem_rd, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pp_new_ir", ir, 8'hE2);
        chk("pp_new_valid", ir_valid, 1'b1);
        fixed_waits = 3;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pp_drained", ir_valid, 1'b0);

        // reset in the middle of a request
        chk("mid_rst_req", mem_rd, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid_rst_before", mem_rd, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid_rst_rd", mem_rd, 1'b0);
        chk("mid_rst_valid", ir_valid, 1'b0);

        // randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic       fl_v;
            logic [7:0] tg;
            if ($urandom_range(0, 99) < 4) h = ~h;
            fl_v = ($urandom_range(0, 99) < 3);
            tg   = 8'($urandom);
            cyc((i >= 2000) && (i < 2002), ($urandom_range(0, 99) < 70), fl_v, h, tg);
        end
        chk("progress", n_pop > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 8-bit microprocessor. Sits directly downstream of the program counter. It reads `PC`, issues a read to program memory, and captures the returned byte into a 2-entry instruction queue that feeds decode. It pulses `PC_inc` once per accepted fetch and supports flush (branch/jump) and halt.

## Interface
Parameters:
- `ADDR_W`, 8, width of `PC` / memory address.
- `DATA_W`, 8, instruction width.

Ports:
- Reset is synchronous, active-high; one clock.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PC` in ADDR_W: current program counter.
- `PC_inc` out 1: one-cycle increment request to the PC.
- `mem_rd` out 1: memory read request.
- `mem_addr` out ADDR_W: read address, equals `PC` at all times.
- `mem_rdy` in 1: memory has valid `mem_data` this cycle, meaningful only while `mem_rd`=1.
- `mem_data` in DATA_W: read data.
- `ir` out DATA_W: instruction at queue head.
- `ir_valid` out 1: queue non-empty.
- `ir_ready` in 1: decode accepts `ir` this cycle.
- `flush` in 1: discard queue and any outstanding fetch; PC is being loaded.
- `halt` in 1: do not start new requests.

## Operation
- States: FLUSH, REQ, INC, FULL. Reset state is FLUSH.
- Queue: 2 entries, with registered `count` 0..2 and head/tail pointers.
  - `ir` = head entry (0 when empty); `ir_valid` = (`count` != 0).
  - Pop when `ir_valid` & `ir_ready`.
  - Push when state=REQ & `mem_rdy` & ~`flush`.
  - Push and pop in the same cycle are allowed; `count` is unchanged.
- `mem_rd` = (state==REQ). `PC_inc` = (state==INC) & ~`flush`.
- FLUSH: `mem_rd`=0, `PC_inc`=0. Next state is REQ if ~`halt`, else stays in FLUSH.
- REQ: `mem_rd` held at 1 until `mem_rdy`.
  - On an edge with `mem_rdy`=1: push `mem_data` and go to INC.
  - Otherwise stay in REQ. `halt` does not abort an outstanding request.
- INC: `PC_inc`=1 for exactly this cycle.
  - Next state is FULL if post-edge `count`==2 or `halt`=1; otherwise REQ.
- FULL: idle. Next state is REQ when post-edge `count`<2 and ~`halt`.
- `flush`=1 at any edge, in any state, has top priority:
  - queue cleared (`count`←0, pointers←0);
  - next state FLUSH;
  - a `mem_rdy` response in that cycle is discarded;
  - a pop in that cycle is ignored;
  - `PC_inc` is suppressed combinationally in that cycle.
- Width rules: `count` is 2 bits; pointers are 1 bit and wrap naturally.

## Timing
- Reset values (`rst`=1 at an edge): state=FLUSH, `count`=0, pointers=0, queue entries=0. Consequently `mem_rd`=0, `PC_inc`=0, `ir_valid`=0, `ir`=0.
- First `mem_rd`=1 occurs in the 2nd cycle after `rst` deasserts (the FLUSH cycle, then REQ).
- Zero-wait memory (`mem_rdy`=1 in the first REQ cycle):
  - `ir_valid` rises in the INC cycle, i.e. 1 cycle after REQ.
  - Sustained throughput is 1 instruction per 2 cycles (REQ, INC alternating).
- The next REQ always follows the INC cycle, so `mem_addr` reflects the incremented `PC`.
- Each `mem_rdy` wait cycle adds 1 cycle; `mem_rd` and `mem_addr` stay stable throughout.
- After `flush`: 1 FLUSH cycle, then REQ on the newly loaded `PC`.
- `rst` mid-request: the request is abandoned immediately; `mem_rd`=0 the next cycle.

## Test plan
- **Reset/startup**: hold `rst` 2 cycles, zero-wait memory returning `mem_data`=`PC`+8'h10, `ir_ready`=1.
  - `mem_rd` low for 1 cycle after release.
  - Then `ir` sequence 8'h10, 8'h11, 8'h12…, one per 2 cycles.
  - Exactly one `PC_inc` pulse per instruction.
- **Wait states**: `mem_rdy` delayed 3 cycles per fetch.
  - `mem_rd` high for 4 cycles with `mem_addr` constant.
  - Single `PC_inc` per fetch; no duplicate pushes.
- **Backpressure**: `ir_ready`=0.
  - After 2 fetches `count`=2, state FULL, `mem_rd`=0, `ir` holds the first byte.
  - Raise `ir_ready` for 1 cycle: the next REQ begins the following cycle and `ir` advances to the second byte.
- **Flush**: assert `flush` during a REQ cycle with `mem_rdy`=1 and 1 queued entry.
  - Queue empties (`ir_valid`=0 next cycle); the response is dropped and no `PC_inc` occurs.
  - Next `mem_rd` goes to the new `PC` after 1 FLUSH cycle.
  - Repeat with `flush` in the INC cycle: `PC_inc` must be 0 that cycle.
- **Halt**: assert `halt` while in REQ with `mem_rdy` delayed.
  - The outstanding fetch completes and pulses `PC_inc`, then the state enters FULL with `mem_rd`=0.
  - Deassert `halt`: REQ resumes the next cycle.
- **Simultaneous push/pop**: `count`=1 with `ir_ready`=1 and a `mem_rdy` response in the same cycle.
  - `count` stays 1; `ir` switches to the new byte; no instruction is lost or reordered.
